// File: rtl/inst_rom_arb_pkg.sv
// Shared bus macros and arbitration types for the instruction-ROM arbiter.
// Macros are guarded so this file can sit alongside a project-wide defines.v.
`ifndef INST_ROM_ARB_DEFINES
`define INST_ROM_ARB_DEFINES
`define RstEnable    1'b1
`define ChipEnable   1'b1
`define ChipDisable  1'b0
`define ZeroWord     32'h0000_0000
`define InstAddrBus  31:0
`define InstBus      31:0
`define StarveCntBus 2:0
`endif

package inst_rom_arb_pkg;

  localparam int STARVE_CNT_W = 3;

  // Which requester currently owns the ROM port.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IF,
    SRC_DR
  } rom_src_e;

  // Data reads are word-only; any nonzero low byte-address bits are misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_arb.sv
// Arbitrates one combinational instruction ROM between the fetch port and a
// data-side read port, with a bounded-starvation guarantee for the data port.
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int StarveLimit = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [`InstAddrBus] if_addr,
  output logic                if_gnt,
  output logic [`InstBus]     if_inst,
  output logic                if_valid,
  input  logic                dr_req,
  input  logic [`InstAddrBus] dr_addr,
  output logic                dr_gnt,
  output logic [`InstBus]     dr_data,
  output logic                dr_valid,
  output logic                dr_err,
  output logic                rom_ce,
  output logic [`InstAddrBus] rom_addr,
  input  logic [`InstBus]     rom_inst,
  output logic                stallreq_if
);

  if (StarveLimit < 1 || StarveLimit > 7) begin : g_bad_limit
    $error("inst_rom_arb: StarveLimit must be in 1..7");
  end

  localparam logic [`StarveCntBus] STARVE_MAX = STARVE_CNT_W'(StarveLimit);

  logic [`StarveCntBus] starve_cnt;
  logic                 dr_mis;
  logic                 in_reset;
  rom_src_e             rom_src;

  assign in_reset = (rst == `RstEnable);
  assign dr_mis   = is_misaligned(dr_addr[1:0]);

  // A misaligned data read never touches the ROM, so it can be accepted in
  // parallel with a fetch; otherwise at most one requester wins.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    if_gnt  = 1'b0;
    dr_gnt  = 1'b0;
    rom_src = SRC_NONE;
    if (!in_reset) begin
      if (dr_req && dr_mis) begin
        dr_gnt = 1'b1;
        if_gnt = if_req;
      end else if (dr_req && if_req) begin
        if (starve_cnt == STARVE_MAX) dr_gnt = 1'b1;
        else                          if_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        dr_gnt = dr_req;
      end
    end
    if (if_gnt)                rom_src = SRC_IF;
    else if (dr_gnt && !dr_mis) rom_src = SRC_DR;
  end

  always_comb begin
    rom_ce   = `ChipDisable;
    rom_addr = `ZeroWord;
    case (rom_src)
      SRC_IF: begin
        rom_ce   = `ChipEnable;
        rom_addr = if_addr;
      end
      SRC_DR: begin
        rom_ce   = `ChipEnable;
        rom_addr = dr_addr;
      end
      default: ;
    endcase
  end

  assign stallreq_if = if_req && !if_gnt && !in_reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      starve_cnt <= '0;
    end else if (!dr_req || dr_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      if_inst  <= `ZeroWord;
      if_valid <= 1'b0;
    end else begin
      if_valid <= if_gnt;
      if (if_gnt) if_inst <= rom_inst;
    end
  end

  // Data held between responses; a misaligned response returns zero with dr_err.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      dr_data  <= `ZeroWord;
      dr_valid <= 1'b0;
      dr_err   <= 1'b0;
    end else begin
      dr_valid <= dr_gnt;
      dr_err   <= dr_gnt && dr_mis;
      if (dr_gnt) dr_data <= dr_mis ? `ZeroWord : rom_inst;
    end
  end

endmodule

// File: tb/tb_inst_rom_arb.sv
// Directed bench for inst_rom_arb: grants checked in the request cycle, responses
// checked by a scoreboard monitor one cycle later.
module tb_inst_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dr_req;
  logic [31:0] if_addr, dr_addr;
  logic        if_gnt, dr_gnt, if_valid, dr_valid, dr_err, rom_ce, stallreq_if;
  logic [31:0] if_inst, dr_data, rom_addr, rom_inst;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic        v;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t dr_q[$];
  logic [31:0] if_hold = '0;
  logic [31:0] dr_hold = '0;

  inst_rom_arb #(.StarveLimit(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_inst(if_inst), .if_valid(if_valid),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt), .dr_data(dr_data), .dr_valid(dr_valid),
    .dr_err(dr_err), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ROM: one known word at 0x8, a distinctive pattern elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h3401_1100;
    return {8'hA5, a[23:0]};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One request cycle: apply inputs, check combinational outputs, queue responses.
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dq, input logic [31:0] da,
                      input logic eig, input logic edg, input logic est,
                      input logic ece, input logic [31:0] ea);
    rsp_t e;
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia; dr_req = dq; dr_addr = da;
    #2;
    check("if_gnt", 32'(if_gnt), 32'(eig));
    check("dr_gnt", 32'(dr_gnt), 32'(edg));
    check("stallreq_if", 32'(stallreq_if), 32'(est));
    check("rom_ce", 32'(rom_ce), 32'(ece));
    check("rom_addr", rom_addr, ea);
    if (r) begin
      e = '{cyc: cyc + 1, v: 1'b0, d: 32'h0, e: 1'b0};
      if_q.push_back(e);
      dr_q.push_back(e);
    end else begin
      if (eig) begin
        e = '{cyc: cyc + 1, v: 1'b1, d: rom_word(ia), e: 1'b0};
        if_q.push_back(e);
      end
      if (edg) begin
        if (da[1:0] != 2'b00) e = '{cyc: cyc + 1, v: 1'b1, d: 32'h0, e: 1'b1};
        else                  e = '{cyc: cyc + 1, v: 1'b1, d: rom_word(da), e: 1'b0};
        dr_q.push_back(e);
      end
    end
  endtask

  // Monitor: a queued response must appear exactly in its cycle; otherwise
  // valid stays low and the data output holds its last value.
  always @(negedge clk) begin
    rsp_t e;
    if (mon_en) begin
      if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
        e = if_q.pop_front();
        check("if_valid", 32'(if_valid), 32'(e.v));
        check("if_inst", if_inst, e.d);
        if_hold = e.d;
      end else begin
        check("if_valid_idle", 32'(if_valid), 32'h0);
        check("if_inst_hold", if_inst, if_hold);
      end
      if (dr_q.size() > 0 && dr_q[0].cyc == cyc) begin
        e = dr_q.pop_front();
        check("dr_valid", 32'(dr_valid), 32'(e.v));
        check("dr_data", dr_data, e.d);
        check("dr_err", 32'(dr_err), 32'(e.e));
        dr_hold = e.d;
      end else begin
        check("dr_valid_idle", 32'(dr_valid), 32'h0);
        check("dr_data_hold", dr_data, dr_hold);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dr_req = 1'b0; dr_addr = '0;
    //    rst ifr if_addr   drr dr_addr   ifg drg stall ce  rom_addr
    step(1, 1, 32'h08, 1, 32'h10, 0, 0, 0, 0, 32'h00);  // requests ignored in reset
    mon_en = 1'b1;
    step(0, 1, 32'h08, 0, 32'h00, 1, 0, 0, 1, 32'h08);  // fetch only
    step(0, 0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 32'h00);  // idle, data held
    step(0, 0, 32'h00, 1, 32'h10, 0, 1, 0, 1, 32'h10);  // data only
    // Both requesting: fetch wins three times, then data is forced through.
    step(0, 1, 32'h20, 1, 32'h40, 1, 0, 0, 1, 32'h20);
    step(0, 1, 32'h24, 1, 32'h40, 1, 0, 0, 1, 32'h24);
    step(0, 1, 32'h28, 1, 32'h40, 1, 0, 0, 1, 32'h28);
    step(0, 1, 32'h2C, 1, 32'h40, 0, 1, 1, 1, 32'h40);
    // Starvation count restarts: two losses, drop, then three more losses.
    step(0, 1, 32'h2C, 1, 32'h44, 1, 0, 0, 1, 32'h2C);
    step(0, 1, 32'h30, 1, 32'h44, 1, 0, 0, 1, 32'h30);
    step(0, 1, 32'h34, 0, 32'h00, 1, 0, 0, 1, 32'h34);
    step(0, 1, 32'h38, 1, 32'h44, 1, 0, 0, 1, 32'h38);
    step(0, 1, 32'h3C, 1, 32'h44, 1, 0, 0, 1, 32'h3C);
    step(0, 1, 32'h48, 1, 32'h44, 1, 0, 0, 1, 32'h48);
    step(0, 1, 32'h4C, 1, 32'h44, 0, 1, 1, 1, 32'h44);
    // Misaligned data read: accepted alongside fetch, no ROM access for it.
    step(0, 1, 32'h4C, 1, 32'h06, 1, 1, 0, 1, 32'h4C);
    step(0, 0, 32'h00, 1, 32'h03, 0, 1, 0, 0, 32'h00);
    step(0, 0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 32'h00);
    // Reset during traffic clears responses and the starvation count.
    step(0, 1, 32'h60, 1, 32'h80, 1, 0, 0, 1, 32'h60);
    step(0, 1, 32'h64, 1, 32'h80, 1, 0, 0, 1, 32'h64);
    step(1, 1, 32'h68, 1, 32'h80, 0, 0, 0, 0, 32'h00);
    step(0, 1, 32'h68, 1, 32'h80, 1, 0, 0, 1, 32'h68);
    step(0, 1, 32'h6C, 1, 32'h80, 1, 0, 0, 1, 32'h6C);
    step(0, 1, 32'h70, 1, 32'h80, 1, 0, 0, 1, 32'h70);
    step(0, 1, 32'h74, 1, 32'h80, 0, 1, 1, 1, 32'h80);
    step(0, 1, 32'h74, 0, 32'h00, 1, 0, 0, 1, 32'h74);
    step(0, 0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 32'h00);
    step(0, 0, 32'h00, 0, 32'h00, 0, 0, 0, 0, 32'h00);
    @(posedge clk);
    #6;
    check("if_q_drained", 32'(if_q.size()), 32'h0);
    check("dr_q_drained", 32'(dr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
